// File: rtl/dg_fetch_pkg.sv
// Shared types and constants for the DG-series instruction-fetch sequencer.
// Holds the state encoding, opcode classes and the fixed machine-cycle length.
package dg_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        OPER  = 2'd2
    } state_t;

    localparam logic [1:0] OP_OUT   = 2'b00;
    localparam logic [1:0] OP_SKIPK = 2'b01;
    localparam logic [1:0] OP_WAITK = 2'b10;
    localparam logic [1:0] OP_JMP   = 2'b11;

    localparam logic [2:0] PH_LAST    = 3'd7;
    localparam logic [7:0] UIO_OE_VAL = 8'hF0;

    // A key condition holds when any masked key line is high.
    function automatic logic key_hit(input logic [3:0] ks, input logic [3:0] mask);
        return |(ks & mask);
    endfunction

endpackage

// File: rtl/tt_um_bh2vgm_dg0046_fetch_if.sv
// Pin bundle between the fetch sequencer (master) and the ROM/key board (slave).
// Signal names match the TinyTapeout pin names they map onto.
interface tt_um_bh2vgm_dg0046_fetch_if;

    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );

    modport slave (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

endinterface

// File: rtl/dg_kin_sync.sv
// Two-flop synchronizer for the four asynchronous key inputs.
// Runs on every clock, independent of the sequencer enable.
module dg_kin_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] kin_async,
    output logic [3:0] kin_sync
);

    logic [3:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= '0;
            kin_sync <= '0;
        end else begin
            meta     <= kin_async;
            kin_sync <= meta;
        end
    end

endmodule

// File: rtl/tt_um_bh2vgm_dg0046_fetch.sv
// Instruction-fetch sequencer: eight enabled clocks per machine cycle, PC on uo_out,
// ROM byte sampled on SAMPLE_PH, instruction executed on the last phase.
module tt_um_bh2vgm_dg0046_fetch
    import dg_fetch_pkg::*;
#(
    parameter logic [2:0] SAMPLE_PH = 3'd4,
    parameter logic [7:0] PC_RST    = 8'h00
) (
    input  logic                              clk,
    input  logic                              rst_n,
    tt_um_bh2vgm_dg0046_fetch_if.master       bus
);

    state_t     state;
    logic [2:0] ph;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [7:0] op;
    logic [3:0] nl;
    logic [3:0] ks;
    logic [7:0] ir_now;
    logic [7:0] op_now;
    logic       unused_bits;

    dg_kin_sync u_kin_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .kin_async (bus.uio_in[3:0]),
        .kin_sync  (ks)
    );

    // Bypass lets decode see the byte captured on the same edge when SAMPLE_PH is the last phase.
    always_comb begin
        ir_now = ir;
        op_now = op;
        if (ph == SAMPLE_PH) begin
            ir_now = bus.ui_in;
            op_now = bus.ui_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            ph    <= '0;
            pc    <= PC_RST;
            ir    <= '0;
            op    <= '0;
            nl    <= '0;
        end else if (bus.ena) begin
            ph <= ph + 3'd1;

            if (ph == SAMPLE_PH) begin
                case (state)
                    FETCH:   ir <= bus.ui_in;
                    OPER:    op <= bus.ui_in;
                    default: ;
                endcase
            end

            if (ph == PH_LAST) begin
                case (state)
                    FETCH: begin
                        case (ir_now[7:6])
                            OP_OUT: begin
                                nl <= ir_now[3:0];
                                pc <= pc + 8'd1;
                            end
                            OP_SKIPK: begin
                                pc <= key_hit(ks, ir_now[3:0]) ? pc + 8'd2 : pc + 8'd1;
                            end
                            OP_WAITK: begin
                                if (key_hit(ks, ir_now[3:0])) begin
                                    pc <= pc + 8'd1;
                                end else begin
                                    state <= WAIT;
                                end
                            end
                            default: begin
                                pc    <= pc + 8'd1;
                                state <= OPER;
                            end
                        endcase
                    end
                    WAIT: begin
                        if (key_hit(ks, ir[3:0])) begin
                            pc    <= pc + 8'd1;
                            state <= FETCH;
                        end
                    end
                    OPER: begin
                        pc    <= op_now;
                        state <= FETCH;
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end

    assign bus.uo_out  = pc;
    assign bus.uio_out = {nl, 4'b0000};
    assign bus.uio_oe  = UIO_OE_VAL;

    // Upper key pins and opcode bits 5:4 carry no meaning for this sequencer.
    assign unused_bits = &{1'b0, bus.uio_in[7:4], ir_now[5:4]};

endmodule

// File: tb/tb_tt_um_bh2vgm_dg0046_fetch.sv
// Self-checking bench for the fetch sequencer: directed scenarios plus randomized
// ROM/enable/key traffic compared against an instruction-level reference model.
module tb_tt_um_bh2vgm_dg0046_fetch;

    localparam int         SAMPLE_PH = 4;
    localparam logic [7:0] PC_RST    = 8'h00;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    tt_um_bh2vgm_dg0046_fetch_if bus ();

    tt_um_bh2vgm_dg0046_fetch #(
        .SAMPLE_PH (3'(SAMPLE_PH)),
        .PC_RST    (PC_RST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] rom [256];

    // Reference model: mode 0 = fetching, 1 = waiting on keys, 2 = fetching a jump target.
    int         m_ph;
    int         m_mode;
    logic [7:0] m_pc;
    logic [7:0] m_ir;
    logic [7:0] m_op;
    logic [3:0] m_nl;
    logic [3:0] kin_prev1;
    logic [3:0] kin_prev2;

    int tests = 0;
    int fails = 0;

    task automatic check_output(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph      = 0;
        m_mode    = 0;
        m_pc      = PC_RST;
        m_ir      = 8'h00;
        m_op      = 8'h00;
        m_nl      = 4'h0;
        kin_prev1 = 4'h0;
        kin_prev2 = 4'h0;
    endtask

    task automatic check_model();
        check_output("pc", bus.uo_out, m_pc);
        check_output("nl", bus.uio_out, {m_nl, 4'h0});
        check_output("oe", bus.uio_oe, 8'hF0);
    endtask

    // Executes one instruction-level step at the end of a machine cycle.
    task automatic model_execute(input logic [3:0] ks);
        logic hit;
        case (m_mode)
            0: begin
                hit = (ks & m_ir[3:0]) != 4'h0;
                case (m_ir[7:6])
                    2'b00: begin m_nl = m_ir[3:0]; m_pc = m_pc + 8'd1; end
                    2'b01: m_pc = m_pc + (hit ? 8'd2 : 8'd1);
                    2'b10: if (hit) m_pc = m_pc + 8'd1; else m_mode = 1;
                    default: begin m_pc = m_pc + 8'd1; m_mode = 2; end
                endcase
            end
            1: begin
                if ((ks & m_ir[3:0]) != 4'h0) begin
                    m_pc   = m_pc + 8'd1;
                    m_mode = 0;
                end
            end
            default: begin
                m_pc   = m_op;
                m_mode = 0;
            end
        endcase
    endtask

    // One clock: drive inputs at negedge, advance model at posedge, check 1 ns later.
    task automatic apply_stimulus(input logic ena_v, input logic [3:0] kin_v);
        logic [7:0] junk;
        logic [7:0] junk2;
        logic [3:0] ks;
        junk  = 8'($urandom);
        junk2 = 8'($urandom);
        @(negedge clk);
        bus.ena    = ena_v;
        bus.uio_in = {junk[7:4], kin_v};
        bus.ui_in  = (m_ph == SAMPLE_PH) ? rom[m_pc] : junk2;
        @(posedge clk);
        ks        = kin_prev2;
        kin_prev2 = kin_prev1;
        kin_prev1 = kin_v;
        if (ena_v) begin
            if (m_ph == SAMPLE_PH) begin
                if (m_mode == 0) m_ir = rom[m_pc];
                else if (m_mode == 2) m_op = rom[m_pc];
            end
            if (m_ph == 7) model_execute(ks);
            m_ph = (m_ph + 1) % 8;
        end
        #1;
        check_model();
    endtask

    // Asynchronous reset asserted between edges; outputs must react without a clock.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_pc", bus.uo_out, PC_RST);
        check_output("rst_nl", bus.uio_out, 8'h00);
        check_output("rst_oe", bus.uio_oe, 8'hF0);
        repeat (2) @(negedge clk);
        bus.ena    = 1'b0;
        bus.uio_in = 8'h00;
        rst_n      = 1'b1;
        model_reset();
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    initial begin
        bus.ena    = 1'b0;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        rst_n      = 1'b1;
        clear_rom();
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        check_output("por_pc", bus.uo_out, PC_RST);
        check_output("por_nl", bus.uio_out, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) apply_stimulus(1'b0, 4'h0);
        check_output("idle_pc", bus.uo_out, 8'h00);

        // OUT stream
        rom[0] = 8'h05;
        rom[1] = 8'h0A;
        do_reset();
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 4'h0);
        check_output("out1_nl", bus.uio_out, 8'h50);
        check_output("out1_pc", bus.uo_out, 8'h01);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 4'h0);
        check_output("out2_nl", bus.uio_out, 8'hA0);
        check_output("out2_pc", bus.uo_out, 8'h02);

        // JMP, including one at 0xFF whose operand wraps to 0x00
        clear_rom();
        rom[8'h00] = 8'hC0;
        rom[8'h01] = 8'hFF;
        rom[8'hFF] = 8'hC0;
        do_reset();
        for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 4'h0);
        check_output("jmp1_pc", bus.uo_out, 8'hFF);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 4'h0);
        check_output("jmpw_op", bus.uo_out, 8'h00);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 4'h0);
        check_output("jmp2_pc", bus.uo_out, 8'hC0);

        // SKIPK taken and not taken
        clear_rom();
        rom[0] = 8'h43;
        do_reset();
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 4'b0010);
        check_output("skip_hit", bus.uo_out, 8'h02);
        do_reset();
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 4'b1000);
        check_output("skip_miss", bus.uo_out, 8'h01);

        // SKIPK wrapping past 0xFF
        clear_rom();
        rom[0]     = 8'hC0;
        rom[1]     = 8'hFF;
        rom[8'hFF] = 8'h41;
        do_reset();
        for (int i = 0; i < 24; i++) apply_stimulus(1'b1, 4'h1);
        check_output("skip_wrap", bus.uo_out, 8'h01);

        // WAITK: stalls, then completes only at a last phase after sync
        clear_rom();
        rom[0] = 8'h81;
        do_reset();
        for (int i = 0; i < 40; i++) apply_stimulus(1'b1, 4'h0);
        check_output("wait_hold", bus.uo_out, 8'h00);
        for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 4'h0);
        apply_stimulus(1'b1, 4'h1);
        check_output("wait_early", bus.uo_out, 8'h00);
        apply_stimulus(1'b1, 4'h1);
        check_output("wait_late", bus.uo_out, 8'h00);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 4'h1);
        check_output("wait_done", bus.uo_out, 8'h01);

        // Reset in the middle of a jump's operand cycle
        clear_rom();
        rom[0] = 8'hC0;
        rom[1] = 8'h20;
        do_reset();
        for (int i = 0; i < 11; i++) apply_stimulus(1'b1, 4'h0);
        do_reset();
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 4'h0);
        check_output("rst_jmp_pc", bus.uo_out, 8'h01);

        // Enable frozen for 30 clocks mid-cycle
        clear_rom();
        rom[0] = 8'h05;
        rom[1] = 8'h0A;
        do_reset();
        apply_stimulus(1'b1, 4'h0);
        apply_stimulus(1'b1, 4'h0);
        for (int i = 0; i < 30; i++) apply_stimulus(1'b0, 4'h0);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 4'h0);
        check_output("frz_pre", bus.uo_out, 8'h00);
        apply_stimulus(1'b1, 4'h0);
        check_output("frz_pc", bus.uo_out, 8'h01);
        check_output("frz_nl", bus.uio_out, 8'h50);

        // Randomized traffic
        for (int r = 0; r < 6; r++) begin
            logic [3:0] kin;
            for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
            do_reset();
            kin = 4'h0;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 7) == 0) kin = 4'($urandom);
                if ($urandom_range(0, 399) == 0) do_reset();
                apply_stimulus($urandom_range(0, 4) != 0, kin);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
